// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit placed behind the EX/MEM pipeline register.
//   It issues one request at a time on a req/ack data bus, formats store
//   byte lanes, extracts and extends load data, stalls upstream while an
//   access is in flight and emits one result per instruction to MEM/WB.
//
//   Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN
//     defined   - misaligned halfword/word accesses skip the bus and return a
//                 one-cycle misalign_out flag with the address as wb_data.
//     undefined - misalign_out is tied low; halfword ops ignore alu[0] and
//                 word ops ignore alu[1:0].
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   alu_in, rd_addr_in,
//   rs2_data_in, wr_en_in    EX/MEM operands
//   str_en_in, sb/sh/sw_en_in          store flags
//   load_en_in, lb/lh/lw/lbu/lhu_en_in load flags
//   mem_req/we/addr/wdata/wstrb        bus request side (registered)
//   mem_ack, mem_rdata                 bus response side
//   stall_out                upstream hold
//   wb_valid, wb_rd_addr,
//   wb_data, wb_wr_en        result strobe to MEM/WB
//   misalign_out             one-cycle misaligned-access flag
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [31:0] rs2_data_in,
  input  logic        wr_en_in,
  input  logic        str_en_in,
  input  logic        sb_en_in,
  input  logic        sh_en_in,
  input  logic        sw_en_in,
  input  logic        load_en_in,
  input  logic        lb_en_in,
  input  logic        lh_en_in,
  input  logic        lw_en_in,
  input  logic        lbu_en_in,
  input  logic        lhu_en_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        wb_wr_en,
  output logic        misalign_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {ST_B, ST_H, ST_W} st_size_t;
  typedef enum logic [2:0] {LD_W, LD_H, LD_HU, LD_B, LD_BU} ld_kind_t;

  state_t   state_reg, state_next;
  st_size_t st_size;
  ld_kind_t ld_kind, ld_kind_reg;

  logic [1:0]  off;
  logic        is_mem, is_store;
  logic        misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  logic        mem_req_reg, mem_we_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;
  logic [1:0]  off_reg;
  logic [4:0]  rd_reg;
  logic        wr_en_reg, is_load_reg;
  logic        wb_valid_reg, wb_wr_en_reg, misalign_reg;
  logic [4:0]  wb_rd_addr_reg;
  logic [31:0] wb_data_reg;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign off      = alu_in[1:0];
  assign is_mem   = str_en_in | load_en_in;
  assign is_store = str_en_in;          // store wins when both flags are set

  // Size decode with fixed priority; a missing size flag means a word access.
  always_comb begin
    st_size = ST_W;
    if (sw_en_in)      st_size = ST_W;
    else if (sh_en_in) st_size = ST_H;
    else if (sb_en_in) st_size = ST_B;

    ld_kind = LD_W;
    if (lw_en_in)       ld_kind = LD_W;
    else if (lh_en_in)  ld_kind = LD_H;
    else if (lhu_en_in) ld_kind = LD_HU;
    else if (lb_en_in)  ld_kind = LD_B;
    else if (lbu_en_in) ld_kind = LD_BU;
  end

  // Store lane replication: the memory picks the lane via the strobes.
  always_comb begin
    st_wdata = rs2_data_in;
    st_wstrb = 4'b1111;
    case (st_size)
      ST_B: begin
        st_wdata = {4{rs2_data_in[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      ST_H: begin
        st_wdata = {2{rs2_data_in[15:0]}};
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic half_acc, word_acc;
  always_comb begin
    half_acc = is_store ? (st_size == ST_H) : (ld_kind == LD_H || ld_kind == LD_HU);
    word_acc = is_store ? (st_size == ST_W) : (ld_kind == LD_W);
    misalign = is_mem & ((half_acc & off[0]) | (word_acc & (|off)));
  end
`else
  assign misalign = 1'b0;
`endif

  // Load extraction from the latched offset and kind.
  always_comb begin
    case (off_reg)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_kind_reg)
      LD_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {24'h0, ld_byte};
      LD_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and the combinational stall.
  always_comb begin
    state_next = state_reg;
    stall_out  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (is_mem && !misalign) begin
          stall_out  = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_out = 1'b1;
        if (mem_ack) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;  // upstream advances on this edge
      default: state_next = S_IDLE;
    endcase
  end

  // Bus request and writeback datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= 32'h0;
      mem_wdata_reg  <= 32'h0;
      mem_wstrb_reg  <= 4'h0;
      ld_kind_reg    <= LD_W;
      off_reg        <= 2'b00;
      rd_reg         <= 5'h0;
      wr_en_reg      <= 1'b0;
      is_load_reg    <= 1'b0;
      wb_valid_reg   <= 1'b0;
      wb_wr_en_reg   <= 1'b0;
      wb_rd_addr_reg <= 5'h0;
      wb_data_reg    <= 32'h0;
      misalign_reg   <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      misalign_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (is_mem && misalign) begin
            wb_valid_reg   <= 1'b1;
            misalign_reg   <= 1'b1;
            wb_wr_en_reg   <= 1'b0;
            wb_data_reg    <= alu_in;
            wb_rd_addr_reg <= rd_addr_in;
          end else if (is_mem) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= is_store;
            mem_addr_reg  <= {alu_in[31:2], 2'b00};
            mem_wdata_reg <= is_store ? st_wdata : 32'h0;
            mem_wstrb_reg <= is_store ? st_wstrb : 4'h0;
            ld_kind_reg   <= ld_kind;
            off_reg       <= off;
            rd_reg        <= rd_addr_in;
            wr_en_reg     <= wr_en_in;
            is_load_reg   <= ~is_store;
          end else begin
            // ALU op or bubble: one-cycle pass-through.
            wb_valid_reg   <= 1'b1;
            wb_data_reg    <= alu_in;
            wb_rd_addr_reg <= rd_addr_in;
            wb_wr_en_reg   <= wr_en_in;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req_reg    <= 1'b0;
            wb_valid_reg   <= 1'b1;
            wb_rd_addr_reg <= rd_reg;
            wb_wr_en_reg   <= is_load_reg & wr_en_reg;
            wb_data_reg    <= is_load_reg ? ld_data : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req      = mem_req_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_wstrb    = mem_wstrb_reg;
  assign wb_valid     = wb_valid_reg;
  assign wb_rd_addr   = wb_rd_addr_reg;
  assign wb_data      = wb_data_reg;
  assign wb_wr_en     = wb_wr_en_reg;
  assign misalign_out = misalign_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed operations, a memory responder with
// programmable wait states, and scoreboard queues for bus and writeback
// traffic checked by independent monitor processes.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] alu_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] rs2_data_in;
  logic        wr_en_in;
  logic        str_en_in, sb_en_in, sh_en_in, sw_en_in;
  logic        load_en_in, lb_en_in, lh_en_in, lw_en_in, lbu_en_in, lhu_en_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_out, wb_valid, wb_wr_en, misalign_out;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  logic        ack_r, force_ack;
  int          ack_delay;
  logic [31:0] rdata_cfg;
  int          cyc;
  int          checks, errors;

  // flag vector: {str,sb,sh,sw,ld,lb,lh,lw,lbu,lhu}
  localparam logic [9:0] OP_ALU = 10'h000;
  localparam logic [9:0] OP_SW  = 10'h240;
  localparam logic [9:0] OP_SH  = 10'h280;
  localparam logic [9:0] OP_SB  = 10'h300;
  localparam logic [9:0] OP_ST0 = 10'h200;
  localparam logic [9:0] OP_SHB = 10'h380;
  localparam logic [9:0] OP_SWL = 10'h264;
  localparam logic [9:0] OP_LB  = 10'h030;
  localparam logic [9:0] OP_LH  = 10'h028;
  localparam logic [9:0] OP_LW  = 10'h024;
  localparam logic [9:0] OP_LBU = 10'h022;
  localparam logic [9:0] OP_LHU = 10'h021;
  localparam logic [9:0] OP_LD0 = 10'h020;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        wr;
    logic        mis;
    int          cyc;
  } wb_exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [3:0]  wstrb;
    int          delay;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];

  assign mem_ack = ack_r | force_ack;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .alu_in(alu_in), .rd_addr_in(rd_addr_in), .rs2_data_in(rs2_data_in),
    .wr_en_in(wr_en_in),
    .str_en_in(str_en_in), .sb_en_in(sb_en_in), .sh_en_in(sh_en_in), .sw_en_in(sw_en_in),
    .load_en_in(load_en_in), .lb_en_in(lb_en_in), .lh_en_in(lh_en_in), .lw_en_in(lw_en_in),
    .lbu_en_in(lbu_en_in), .lhu_en_in(lhu_en_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .wb_wr_en(wb_wr_en), .misalign_out(misalign_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay request cycles, checks the request.
  initial begin
    int wait_cnt;
    int req_cycles;
    bus_exp_t b;
    ack_r = 1'b0;
    mem_rdata = 32'h0;
    wait_cnt = 0;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst === 1'b0) begin
        req_cycles++;
        if (wait_cnt >= ack_delay) begin
          ack_r = 1'b1;
          mem_rdata = rdata_cfg;
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got request addr=%h, expected none", mem_addr);
          end else begin
            b = bus_q.pop_front();
            chk({b.name, "_we"}, {31'h0, mem_we}, {31'h0, b.we});
            chk({b.name, "_addr"}, mem_addr, b.addr);
            chk({b.name, "_wstrb"}, {28'h0, mem_wstrb}, {28'h0, b.wstrb});
            if (b.chk_wdata) chk({b.name, "_wdata"}, mem_wdata, b.wdata);
            chk({b.name, "_req_cycles"}, req_cycles, b.delay + 1);
          end
          wait_cnt = 0;
          req_cycles = 0;
        end else begin
          ack_r = 1'b0;
          wait_cnt++;
        end
      end else begin
        ack_r = 1'b0;
        wait_cnt = 0;
        req_cycles = 0;
      end
    end
  end

  // Writeback monitor.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got wb_valid=1 rd=%0d data=%h, expected no result",
                   wb_rd_addr, wb_data);
        end else begin
          e = wb_q.pop_front();
          chk({e.name, "_cycle"}, cyc, e.cyc);
          chk({e.name, "_wr_en"}, {31'h0, wb_wr_en}, {31'h0, e.wr});
          chk({e.name, "_misalign"}, {31'h0, misalign_out}, {31'h0, e.mis});
          if (!e.mis) chk({e.name, "_rd"}, {27'h0, wb_rd_addr}, {27'h0, e.rd});
          if (e.chk_data) chk({e.name, "_data"}, wb_data, e.data);
          $display("wb %s: rd=%0d data=%h wr=%0d mis=%0d cycle=%0d",
                   e.name, wb_rd_addr, wb_data, wb_wr_en, misalign_out, cyc);
        end
      end
    end
  end

  task automatic set_inputs(input logic [9:0] fl, input logic [31:0] alu,
                            input logic [4:0] rd, input logic [31:0] rs2, input logic wr);
    {str_en_in, sb_en_in, sh_en_in, sw_en_in, load_en_in,
     lb_en_in, lh_en_in, lw_en_in, lbu_en_in, lhu_en_in} = fl;
    alu_in = alu;
    rd_addr_in = rd;
    rs2_data_in = rs2;
    wr_en_in = wr;
  endtask

  // Called at posedge+1; presents one op, queues expectations, returns at
  // posedge+1 of the edge that retires it upstream.
  task automatic issue(input string name, input logic [9:0] fl, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [31:0] rs2, input logic wr,
                       input int delay, input logic [31:0] rdata,
                       input logic bus, input logic [31:0] b_addr, input logic b_we,
                       input logic [31:0] b_wdata, input logic [3:0] b_wstrb,
                       input logic [31:0] w_data, input logic w_chk, input logic w_wr,
                       input logic w_mis, input int lat);
    wb_exp_t  e;
    bus_exp_t b;
    int n;
    ack_delay = delay;
    rdata_cfg = rdata;
    set_inputs(fl, alu, rd, rs2, wr);
    if (bus) begin
      b.name = name; b.we = b_we; b.addr = b_addr; b.wdata = b_wdata;
      b.chk_wdata = b_we; b.wstrb = b_wstrb; b.delay = delay;
      bus_q.push_back(b);
    end
    e.name = name; e.rd = rd; e.data = w_data; e.chk_data = w_chk;
    e.wr = w_wr; e.mis = w_mis; e.cyc = cyc + lat;
    wb_q.push_back(e);
    n = 0;
    @(negedge clk);
    chk({name, "_stall0"}, {31'h0, stall_out}, {31'h0, bus});
    while (stall_out === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (bus) chk({name, "_stall_cycles"}, n, delay + 2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    wb_exp_t e;
    checks = 0;
    errors = 0;
    cyc = 0;
    force_ack = 1'b0;
    ack_delay = 0;
    rdata_cfg = 32'h0;
    set_inputs(OP_ALU, 32'h0, 5'd0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("reset_stall", {31'h0, stall_out}, 32'h0);
    chk("reset_outputs", {mem_we, mem_wstrb, wb_wr_en, misalign_out, wb_rd_addr} , 32'h0);
    chk("reset_addr", mem_addr | mem_wdata | wb_data, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    //     name        flags   alu           rd  rs2           wr  dly rdata         bus addr          we    wdata         wstrb    wb_data       chk wr mis lat
    issue("sw_align",  OP_SW,  32'h00000104, 1,  32'hDEADBEEF, 1,  0,  32'h0,        1, 32'h00000104, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0,        0,  0, 0,  2);
    issue("lb_sext",   OP_LB,  32'h00000203, 5,  32'h0,        1,  0,  32'h80112233, 1, 32'h00000200, 1'b0, 32'h0,        4'b0000, 32'hFFFFFF80, 1,  1, 0,  2);
    issue("lbu_zext",  OP_LBU, 32'h00000203, 5,  32'h0,        1,  0,  32'h80112233, 1, 32'h00000200, 1'b0, 32'h0,        4'b0000, 32'h00000080, 1,  1, 0,  2);
    issue("sh_wait3",  OP_SH,  32'h00000102, 2,  32'h1234ABCD, 0,  3,  32'h0,        1, 32'h00000100, 1'b1, 32'hABCDABCD, 4'b1100, 32'h0,        0,  0, 0,  5);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    issue("lw_mis",    OP_LW,  32'h00000101, 4,  32'h0,        1,  0,  32'hCAFEF00D, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h00000101, 1,  0, 1,  1);
    issue("lh_mis",    OP_LH,  32'h00000301, 6,  32'h0,        1,  0,  32'h12348765, 0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h00000301, 1,  0, 1,  1);
`else
    issue("lw_mis",    OP_LW,  32'h00000101, 4,  32'h0,        1,  0,  32'hCAFEF00D, 1, 32'h00000100, 1'b0, 32'h0,        4'b0000, 32'hCAFEF00D, 1,  1, 0,  2);
    issue("lh_mis",    OP_LH,  32'h00000301, 6,  32'h0,        1,  0,  32'h12348765, 1, 32'h00000300, 1'b0, 32'h0,        4'b0000, 32'hFFFF8765, 1,  1, 0,  2);
`endif
    issue("alu_a",     OP_ALU, 32'h00000055, 3,  32'h0,        1,  0,  32'h0,        0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h00000055, 1,  1, 0,  1);
    issue("alu_b",     OP_ALU, 32'h000000AA, 7,  32'h0,        1,  0,  32'h0,        0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h000000AA, 1,  1, 0,  1);
    issue("bubble",    OP_ALU, 32'h00000000, 0,  32'h0,        0,  0,  32'h0,        0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h00000000, 1,  0, 0,  1);
    issue("lh_hi",     OP_LH,  32'h00000302, 6,  32'h0,        1,  1,  32'h80017FFF, 1, 32'h00000300, 1'b0, 32'h0,        4'b0000, 32'hFFFF8001, 1,  1, 0,  3);
    issue("lhu_lo",    OP_LHU, 32'h00000300, 8,  32'h0,        1,  0,  32'h8001F234, 1, 32'h00000300, 1'b0, 32'h0,        4'b0000, 32'h0000F234, 1,  1, 0,  2);
    issue("sb_lane2",  OP_SB,  32'h00000402, 11, 32'h1122335A, 0,  0,  32'h0,        1, 32'h00000400, 1'b1, 32'h5A5A5A5A, 4'b0100, 32'h0,        0,  0, 0,  2);
    issue("st_nosize", OP_ST0, 32'h00000500, 12, 32'hA5A50F0F, 0,  2,  32'h0,        1, 32'h00000500, 1'b1, 32'hA5A50F0F, 4'b1111, 32'h0,        0,  0, 0,  4);
    issue("st_beats_ld", OP_SWL, 32'h00000600, 9, 32'h01020304, 1, 0,  32'h0,        1, 32'h00000600, 1'b1, 32'h01020304, 4'b1111, 32'h0,        0,  0, 0,  2);
    issue("ld_nosize", OP_LD0, 32'h00000704, 10, 32'h0,        1,  0,  32'h89ABCDEF, 1, 32'h00000704, 1'b0, 32'h0,        4'b0000, 32'h89ABCDEF, 1,  1, 0,  2);
    issue("sh_over_sb", OP_SHB, 32'h00000800, 13, 32'h0000BEEF, 0, 0,  32'h0,        1, 32'h00000800, 1'b1, 32'hBEEFBEEF, 4'b0011, 32'h0,        0,  0, 0,  2);
    issue("lb_pos",    OP_LB,  32'h00000900, 14, 32'h0,        1,  0,  32'hFFFFFF7F, 1, 32'h00000900, 1'b0, 32'h0,        4'b0000, 32'h0000007F, 1,  1, 0,  2);

    // Reset while a load waits for its ack: access is dropped, no result.
    ack_delay = 50;
    set_inputs(OP_LW, 32'h00000A00, 5'd9, 32'h0, 1'b1);
    @(negedge clk);
    chk("rstmid_stall0", {31'h0, stall_out}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_req_before", {31'h0, mem_req}, 32'h1);
    #2;
    set_inputs(OP_ALU, 32'h0, 5'd0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_req", {31'h0, mem_req}, 32'h0);
    chk("rstmid_stall", {31'h0, stall_out}, 32'h0);
    chk("rstmid_outputs", {mem_we, mem_wstrb, wb_valid, wb_wr_en, misalign_out, wb_rd_addr}, 32'h0);
    chk("rstmid_data", mem_addr | mem_wdata | wb_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_delay = 0;

    // Stale ack while idle: ignored, cycle behaves as a bubble.
    force_ack = 1'b1;
    e.name = "stale_ack"; e.rd = 5'd0; e.data = 32'h0; e.chk_data = 1'b1;
    e.wr = 1'b0; e.mis = 1'b0; e.cyc = cyc + 1;
    wb_q.push_back(e);
    @(negedge clk);
    chk("stale_ack_req", {31'h0, mem_req}, 32'h0);
    chk("stale_ack_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    issue("alu_after", OP_ALU, 32'h00001234, 2, 32'h0, 1, 0, 32'h0, 0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h00001234, 1, 1, 0, 1);

    @(negedge clk);
    #1;
    chk("final_req_idle", {31'h0, mem_req}, 32'h0);
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("bus_queue_empty", bus_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
